// File: rtl/gam_connection_scheduler_pkg.sv
// Shared sizing, connection-entry layout and scheduler states for the GAM
// connection scheduler.
package gam_connection_scheduler_pkg;

  localparam int CLASS_COUNT = 4;
  localparam int NODE_COUNT  = 8;
  localparam int AGE_MAX     = 3;
  localparam int AGE_W       = 8;

  localparam int CLASS_W = $clog2(CLASS_COUNT);
  localparam int NODE_W  = $clog2(NODE_COUNT);

  typedef struct packed {
    logic             presence;
    logic [AGE_W-1:0] age;
  } conn_entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ERR,
    ST_LINK_W1,
    ST_LINK_W2,
    ST_AGE_RD,
    ST_AGE_CHK,
    ST_AGE_WR1,
    ST_AGE_WR2,
    ST_PR_RD,
    ST_PR_CHK,
    ST_PR_WR,
    ST_ROW_END
  } state_t;

  // Index 0 is reserved in both the class and node spaces.
  function automatic logic idx_ok(input int unsigned v, input int unsigned count);
    return (v != 0) && (v < count);
  endfunction

endpackage

// File: rtl/gam_conn_age_sat.sv
// Saturating edge-age incrementer plus the prune expiry compare.
module gam_conn_age_sat
  import gam_connection_scheduler_pkg::*;
(
  input  logic [AGE_W-1:0] age,
  output logic [AGE_W-1:0] age_inc,
  output logic             age_expired
);

  assign age_inc     = (age == '1) ? age : age + 1'b1;
  assign age_expired = (age >= AGE_W'(AGE_MAX));

endmodule

// File: rtl/gam_connection_scheduler.sv
// Owns the single-port GAM connection RAM: serialises learning edge updates
// and the post-learning prune sweep, and reports isolated nodes.
module gam_connection_scheduler
  import gam_connection_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               learn_valid,
  output logic               learn_ready,
  input  logic [CLASS_W-1:0] learn_class,
  input  logic [NODE_W-1:0]  learn_node1,
  input  logic [NODE_W-1:0]  learn_node2,
  input  logic               learning_done,
  output logic               busy,
  output logic               err,
  output logic               prune_done,
  output logic               mem_en,
  output logic               mem_we,
  output logic [CLASS_W-1:0] mem_class,
  output logic [NODE_W-1:0]  mem_row,
  output logic [NODE_W-1:0]  mem_col,
  output logic [AGE_W:0]     mem_wdata,
  input  logic [AGE_W:0]     mem_rdata,
  output logic               inv_we,
  output logic [CLASS_W-1:0] inv_class,
  output logic [NODE_W-1:0]  inv_node
);

  localparam logic [NODE_W:0]  LAST_NODE  = (NODE_W+1)'(NODE_COUNT - 1);
  localparam logic [CLASS_W:0] LAST_CLASS = (CLASS_W+1)'(CLASS_COUNT - 1);

  state_t             state_q, state_d;
  logic [CLASS_W-1:0] cls_q, cls_d;
  logic [NODE_W-1:0]  n1_q, n1_d, n2_q, n2_d;
  // One bit wider than the index so the compare against the last index never wraps.
  logic [NODE_W:0]    idx_q, idx_d, row_q, row_d, live_q, live_d;
  logic [CLASS_W:0]   pcls_q, pcls_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               ld_q, prune_pending_q, prune_pending_d;

  conn_entry_t      rd_entry;
  logic [AGE_W-1:0] age_inc;
  logic             age_expired;
  logic             ld_rise, accept, legal, learn_skip;

  assign rd_entry = mem_rdata;
  assign ld_rise  = learning_done & ~ld_q;
  assign accept   = learn_valid & learn_ready;
  assign legal    = idx_ok(32'(learn_class), CLASS_COUNT) &&
                    idx_ok(32'(learn_node1), NODE_COUNT) &&
                    idx_ok(32'(learn_node2), NODE_COUNT) &&
                    (learn_node1 != learn_node2);
  assign learn_skip = (idx_q == {1'b0, n1_q}) || (idx_q == {1'b0, n2_q});

  gam_conn_age_sat u_age_sat (
    .age         (rd_entry.age),
    .age_inc     (age_inc),
    .age_expired (age_expired)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cls_q           <= '0;
      n1_q            <= '0;
      n2_q            <= '0;
      idx_q           <= '0;
      row_q           <= '0;
      live_q          <= '0;
      pcls_q          <= '0;
      age_q           <= '0;
      ld_q            <= 1'b0;
      prune_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cls_q           <= cls_d;
      n1_q            <= n1_d;
      n2_q            <= n2_d;
      idx_q           <= idx_d;
      row_q           <= row_d;
      live_q          <= live_d;
      pcls_q          <= pcls_d;
      age_q           <= age_d;
      ld_q            <= learning_done;
      prune_pending_q <= prune_pending_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    cls_d           = cls_q;
    n1_d            = n1_q;
    n2_d            = n2_q;
    idx_d           = idx_q;
    row_d           = row_q;
    live_d          = live_q;
    pcls_d          = pcls_q;
    age_d           = age_q;
    prune_pending_d = prune_pending_q | ld_rise;
    learn_ready     = (state_q == ST_IDLE) & ~prune_pending_q & ~learning_done & ~rst;
    busy            = (state_q != ST_IDLE);
    err             = 1'b0;
    prune_done      = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_class       = '0;
    mem_row         = '0;
    mem_col         = '0;
    mem_wdata       = '0;
    inv_we          = 1'b0;
    inv_class       = '0;
    inv_node        = '0;

    case (state_q)
      ST_IDLE: begin
        if (prune_pending_q) begin
          pcls_d  = (CLASS_W+1)'(1);
          row_d   = (NODE_W+1)'(1);
          idx_d   = (NODE_W+1)'(1);
          live_d  = '0;
          state_d = ST_PR_RD;
        end else if (accept) begin
          cls_d   = learn_class;
          n1_d    = learn_node1;
          n2_d    = learn_node2;
          state_d = legal ? ST_LINK_W1 : ST_ERR;
        end
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      ST_LINK_W1: begin
        {mem_en, mem_we} = 2'b11;
        {mem_class, mem_row, mem_col} = {cls_q, n1_q, n2_q};
        mem_wdata = {1'b1, AGE_W'(0)};
        state_d   = ST_LINK_W2;
      end
      ST_LINK_W2: begin
        {mem_en, mem_we} = 2'b11;
        {mem_class, mem_row, mem_col} = {cls_q, n2_q, n1_q};
        mem_wdata = {1'b1, AGE_W'(0)};
        idx_d     = (NODE_W+1)'(1);
        state_d   = ST_AGE_RD;
      end
      ST_AGE_RD: begin
        if (learn_skip) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == LAST_NODE) ? ST_IDLE : ST_AGE_RD;
        end else begin
          mem_en  = 1'b1;
          {mem_class, mem_row, mem_col} = {cls_q, n1_q, idx_q[NODE_W-1:0]};
          state_d = ST_AGE_CHK;
        end
      end
      ST_AGE_CHK: begin
        if (rd_entry.presence) begin
          age_d   = age_inc;
          state_d = ST_AGE_WR1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == LAST_NODE) ? ST_IDLE : ST_AGE_RD;
        end
      end
      ST_AGE_WR1: begin
        {mem_en, mem_we} = 2'b11;
        {mem_class, mem_row, mem_col} = {cls_q, n1_q, idx_q[NODE_W-1:0]};
        mem_wdata = {1'b1, age_q};
        state_d   = ST_AGE_WR2;
      end
      ST_AGE_WR2: begin
        {mem_en, mem_we} = 2'b11;
        {mem_class, mem_row, mem_col} = {cls_q, idx_q[NODE_W-1:0], n1_q};
        mem_wdata = {1'b1, age_q};
        idx_d     = idx_q + 1'b1;
        state_d   = (idx_q == LAST_NODE) ? ST_IDLE : ST_AGE_RD;
      end
      ST_PR_RD: begin
        mem_en  = 1'b1;
        {mem_class, mem_row, mem_col} =
          {pcls_q[CLASS_W-1:0], row_q[NODE_W-1:0], idx_q[NODE_W-1:0]};
        state_d = ST_PR_CHK;
      end
      ST_PR_CHK: begin
        if (rd_entry.presence && age_expired) begin
          age_d   = rd_entry.age;
          state_d = ST_PR_WR;
        end else begin
          if (rd_entry.presence) live_d = live_q + 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == LAST_NODE) ? ST_ROW_END : ST_PR_RD;
        end
      end
      ST_PR_WR: begin
        {mem_en, mem_we} = 2'b11;
        {mem_class, mem_row, mem_col} =
          {pcls_q[CLASS_W-1:0], row_q[NODE_W-1:0], idx_q[NODE_W-1:0]};
        mem_wdata = {1'b0, age_q};
        idx_d     = idx_q + 1'b1;
        state_d   = (idx_q == LAST_NODE) ? ST_ROW_END : ST_PR_RD;
      end
      ST_ROW_END: begin
        inv_we    = (live_q == '0);
        inv_class = pcls_q[CLASS_W-1:0];
        inv_node  = row_q[NODE_W-1:0];
        idx_d     = (NODE_W+1)'(1);
        live_d    = '0;
        state_d   = ST_PR_RD;
        if (row_q == LAST_NODE) begin
          row_d = (NODE_W+1)'(1);
          if (pcls_q == LAST_CLASS) begin
            prune_done      = 1'b1;
            prune_pending_d = ld_rise;
            state_d         = ST_IDLE;
          end else begin
            pcls_d = pcls_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
